// File: rtl/pong_match_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pong_match_ctrl_pkg: state encodings and result/winner codes for the match
// sequencer, the ball block and the renderer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pong_match_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_P1      = 2'd1;
  localparam logic [1:0] RES_P2      = 2'd2;
  localparam logic [1:0] RES_INVALID = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pong_match_ctrl_if.sv
// ----------------------------------------------------------------------------
// pong_match_ctrl_if: start/result inputs and score/status outputs of the
// match sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pong_match_ctrl_if #(
  parameter int SCORE_WIDTH = 4
);
  logic                   i_start;
  logic [1:0]             i_game_result;
  logic                   o_ball_enable;
  logic [SCORE_WIDTH-1:0] o_P1_score;
  logic [SCORE_WIDTH-1:0] o_P2_score;
  logic [1:0]             o_winner;
  logic                   o_point_pulse;
  logic [1:0]             o_state;

  modport master (
    output i_start, i_game_result,
    input  o_ball_enable, o_P1_score, o_P2_score, o_winner, o_point_pulse, o_state
  );

  modport slave (
    input  i_start, i_game_result,
    output o_ball_enable, o_P1_score, o_P2_score, o_winner, o_point_pulse, o_state
  );
endinterface

`default_nettype wire

// File: rtl/pong_match_ctrl_start_edge.sv
// ----------------------------------------------------------------------------
// pong_match_ctrl_start_edge: rising-edge detector for the start button.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pong_match_ctrl_start_edge (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic start,
  output logic      start_rise
);
  logic start_d;

  // Capturing the live level during reset stops a held button from firing.
  always_ff @(posedge clk) begin
    start_d <= start;
  end

  assign start_rise = start & ~start_d & ~rst;
endmodule

`default_nettype wire

// File: rtl/pong_match_ctrl.sv
// ----------------------------------------------------------------------------
// pong_match_ctrl: match sequencer -- serve delay, score keeping, winner.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pong_match_ctrl
  import pong_match_ctrl_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 25000000,
  parameter int SCORE_WIDTH = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  wire logic        i_Clk,
  input  wire logic        i_Reset,
  pong_match_ctrl_if.slave bus
);
  localparam logic [SCORE_WIDTH-1:0] WIN_VAL  = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [CNT_WIDTH-1:0]   CNT_LOAD = CNT_WIDTH'(SERVE_DELAY - 1);

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n;
  logic [SCORE_WIDTH-1:0] p1, p1_n, p2, p2_n;
  logic [1:0]             winner, winner_n;
  logic                   pulse, pulse_n;
  logic                   ball_enable;
  logic                   start_rise;

  pong_match_ctrl_start_edge u_start_edge (
    .clk        (i_Clk),
    .rst        (i_Reset),
    .start      (bus.i_start),
    .start_rise (start_rise)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      p1          <= '0;
      p2          <= '0;
      winner      <= WIN_NONE;
      pulse       <= 1'b0;
      ball_enable <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      p1          <= p1_n;
      p2          <= p2_n;
      winner      <= winner_n;
      pulse       <= pulse_n;
      ball_enable <= (state_n == ST_PLAY);
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    p1_n     = p1;
    p2_n     = p2;
    winner_n = winner;
    pulse_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_n = ST_SERVE;
          cnt_n   = CNT_LOAD;
        end
      end
      ST_SERVE: begin
        // Result is ignored here: the ball clears it while disabled.
        if (cnt == '0) state_n = ST_PLAY;
        else           cnt_n   = cnt - CNT_WIDTH'(1);
      end
      ST_PLAY: begin
        if (bus.i_game_result == RES_P1) begin
          pulse_n = 1'b1;
          p1_n    = p1 + SCORE_WIDTH'(1);
          if (p1_n == WIN_VAL) begin
            state_n  = ST_OVER;
            winner_n = WIN_P1;
          end else begin
            state_n = ST_SERVE;
            cnt_n   = CNT_LOAD;
          end
        end else if (bus.i_game_result == RES_P2) begin
          pulse_n = 1'b1;
          p2_n    = p2 + SCORE_WIDTH'(1);
          if (p2_n == WIN_VAL) begin
            state_n  = ST_OVER;
            winner_n = WIN_P2;
          end else begin
            state_n = ST_SERVE;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          p1_n     = '0;
          p2_n     = '0;
          winner_n = WIN_NONE;
          state_n  = ST_SERVE;
          cnt_n    = CNT_LOAD;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.o_state       = state;
  assign bus.o_ball_enable = ball_enable;
  assign bus.o_P1_score    = p1;
  assign bus.o_P2_score    = p2;
  assign bus.o_winner      = winner;
  assign bus.o_point_pulse = pulse;
endmodule

`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pong_match_ctrl: directed self-checking bench for pong_match_ctrl
// (SERVE_DELAY=4, WIN_SCORE=3).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pong_match_ctrl;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pong_match_ctrl_if #(.SCORE_WIDTH(4)) bus ();

  pong_match_ctrl #(
    .WIN_SCORE   (3),
    .SERVE_DELAY (4),
    .SCORE_WIDTH (4),
    .CNT_WIDTH   (32)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] target, input string tag);
    int i;
    i = 0;
    while (bus.o_state !== target && i < 20) begin
      tick();
      i++;
    end
    check(tag, 8'(bus.o_state), 8'(target));
  endtask

  task automatic start_rise();
    bus.i_start = 1'b0;
    tick();
    bus.i_start = 1'b1;
    tick();
  endtask

  task automatic score(input logic [1:0] res);
    bus.i_game_result = res;
    tick();
    bus.i_game_result = 2'd0;
  endtask

  initial begin
    int n;
    rst               = 1'b1;
    bus.i_start       = 1'b1;
    bus.i_game_result = 2'd0;
    tick();
    tick();
    check("rst_state",  8'(bus.o_state), 8'(S_IDLE));
    check("rst_enable", 8'(bus.o_ball_enable), 8'd0);
    check("rst_p1",     8'(bus.o_P1_score), 8'd0);
    check("rst_p2",     8'(bus.o_P2_score), 8'd0);
    check("rst_winner", 8'(bus.o_winner), 8'd0);
    check("rst_pulse",  8'(bus.o_point_pulse), 8'd0);

    // 1: start held through reset must not fire
    rst = 1'b0;
    tick(); tick(); tick();
    check("held_start_idle",   8'(bus.o_state), 8'(S_IDLE));
    check("held_start_enable", 8'(bus.o_ball_enable), 8'd0);

    // 2: rise enters SERVE for exactly 4 cycles
    start_rise();
    check("rise_serve",        8'(bus.o_state), 8'(S_SERVE));
    check("serve_enable_low",  8'(bus.o_ball_enable), 8'd0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.o_state != S_SERVE) break;
      n++;
    end
    check("serve_cycles", 8'(n), 8'd4);
    check("play_state",   8'(bus.o_state), 8'(S_PLAY));
    check("play_enable",  8'(bus.o_ball_enable), 8'd1);

    // 3: P1 point, result held for 3 cycles counts once
    bus.i_game_result = 2'd1;
    tick();
    check("p1_point_score",  8'(bus.o_P1_score), 8'd1);
    check("p1_point_pulse",  8'(bus.o_point_pulse), 8'd1);
    check("p1_point_enable", 8'(bus.o_ball_enable), 8'd0);
    check("p1_point_state",  8'(bus.o_state), 8'(S_SERVE));
    tick();
    check("pulse_one_cycle", 8'(bus.o_point_pulse), 8'd0);
    check("held_res_p1_a",   8'(bus.o_P1_score), 8'd1);
    tick();
    check("held_res_p1_b",   8'(bus.o_P1_score), 8'd1);
    bus.i_game_result = 2'd0;
    wait_state(S_PLAY, "back_to_play");

    // 5: invalid result and start rise in PLAY are ignored
    score(2'd3);
    check("invalid_state", 8'(bus.o_state), 8'(S_PLAY));
    check("invalid_p1",    8'(bus.o_P1_score), 8'd1);
    check("invalid_p2",    8'(bus.o_P2_score), 8'd0);
    check("invalid_pulse", 8'(bus.o_point_pulse), 8'd0);
    start_rise();
    check("rise_in_play_state", 8'(bus.o_state), 8'(S_PLAY));
    check("rise_in_play_p1",    8'(bus.o_P1_score), 8'd1);

    // 4: P2 wins 1/3; start rise inside SERVE ignored on the first point
    for (int k = 1; k <= 3; k++) begin
      score(2'd2);
      check("p2_point_score", 8'(bus.o_P2_score), 8'(k));
      check("p2_point_pulse", 8'(bus.o_point_pulse), 8'd1);
      if (k == 1) begin
        start_rise();
        check("rise_in_serve_state", 8'(bus.o_state), 8'(S_SERVE));
        check("rise_in_serve_p2",    8'(bus.o_P2_score), 8'd1);
      end
      if (k < 3) wait_state(S_PLAY, "p2_next_play");
    end
    check("p2_win_state",  8'(bus.o_state), 8'(S_OVER));
    check("p2_win_winner", 8'(bus.o_winner), 8'd2);
    check("p2_win_p1",     8'(bus.o_P1_score), 8'd1);
    check("p2_win_enable", 8'(bus.o_ball_enable), 8'd0);
    tick(); tick();
    check("over_hold_state",  8'(bus.o_state), 8'(S_OVER));
    check("over_hold_p2",     8'(bus.o_P2_score), 8'd3);
    check("over_hold_enable", 8'(bus.o_ball_enable), 8'd0);
    start_rise();
    check("restart_state",  8'(bus.o_state), 8'(S_SERVE));
    check("restart_p1",     8'(bus.o_P1_score), 8'd0);
    check("restart_p2",     8'(bus.o_P2_score), 8'd0);
    check("restart_winner", 8'(bus.o_winner), 8'd0);

    // 6: reach 2/1 then reset mid-PLAY while a result is present
    wait_state(S_PLAY, "g2_play1");
    score(2'd1);
    wait_state(S_PLAY, "g2_play2");
    score(2'd1);
    wait_state(S_PLAY, "g2_play3");
    score(2'd2);
    wait_state(S_PLAY, "g2_play4");
    check("pre_reset_p1", 8'(bus.o_P1_score), 8'd2);
    check("pre_reset_p2", 8'(bus.o_P2_score), 8'd1);
    rst               = 1'b1;
    bus.i_game_result = 2'd1;
    tick();
    rst               = 1'b0;
    bus.i_game_result = 2'd0;
    check("mid_rst_state",  8'(bus.o_state), 8'(S_IDLE));
    check("mid_rst_p1",     8'(bus.o_P1_score), 8'd0);
    check("mid_rst_p2",     8'(bus.o_P2_score), 8'd0);
    check("mid_rst_enable", 8'(bus.o_ball_enable), 8'd0);
    check("mid_rst_pulse",  8'(bus.o_point_pulse), 8'd0);

    // P1 wins 3/0 from a fresh match
    start_rise();
    check("g3_serve", 8'(bus.o_state), 8'(S_SERVE));
    for (int k = 1; k <= 3; k++) begin
      wait_state(S_PLAY, "g3_play");
      score(2'd1);
      check("g3_p1_score", 8'(bus.o_P1_score), 8'(k));
    end
    check("p1_win_state",  8'(bus.o_state), 8'(S_OVER));
    check("p1_win_winner", 8'(bus.o_winner), 8'd1);
    check("p1_win_p2",     8'(bus.o_P2_score), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
